// File: rtl/sv39_ptw.sv
// Sv39 page-table walker: walks up to three levels of the page table for one
// TLB miss at a time, issuing one PTE read per level and returning the leaf
// (or faulting) PTE with its level, ASID and a page-fault flag.
module sv39_ptw (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [43:0] satp_ppn_i,
  input  logic        req_valid_i,
  input  logic [26:0] req_vpn_i,
  input  logic [15:0] req_asid_i,
  input  logic        req_store_i,
  input  logic        req_fetch_i,
  output logic        ptw_ready_o,
  output logic        resp_valid_o,
  output logic [63:0] resp_pte_o,
  output logic [1:0]  resp_level_o,
  output logic [15:0] resp_asid_o,
  output logic        resp_error_o,
  output logic        mem_req_valid_o,
  output logic [55:0] mem_req_addr_o,
  input  logic        mem_req_ready_i,
  input  logic        mem_resp_valid_i,
  input  logic [63:0] mem_resp_data_i,
  input  logic        flush_i,
  output logic        invalidate_tlb_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MEM_REQ  = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [26:0] vpn_q, vpn_d;
  logic [15:0] asid_q, asid_d;
  logic [43:0] base_q, base_d;
  logic [1:0]  level_q, level_d;
  logic [63:0] rpte_q, rpte_d;
  logic [1:0]  rlevel_q, rlevel_d;
  logic [15:0] rasid_q, rasid_d;
  logic        rerr_q, rerr_d;

  // Access type does not influence the walk; it is only carried for the TLB.
  logic unused_access_type;
  assign unused_access_type = req_store_i ^ req_fetch_i;

  // PTE field decode of the returning memory data.
  logic        pte_v, pte_r, pte_w, pte_x;
  logic [43:0] pte_ppn;
  logic        pte_bad, pte_leaf, pte_misaligned, pte_fault;
  assign pte_v    = mem_resp_data_i[0];
  assign pte_r    = mem_resp_data_i[1];
  assign pte_w    = mem_resp_data_i[2];
  assign pte_x    = mem_resp_data_i[3];
  assign pte_ppn  = mem_resp_data_i[53:10];
  assign pte_bad  = !pte_v || (!pte_r && pte_w);
  assign pte_leaf = pte_r || pte_x;
  // Superpage leaves must have the PPN bits below their page size cleared.
  assign pte_misaligned = pte_leaf &&
                          (((level_q == 2'd2) && (pte_ppn[17:0] != 18'd0)) ||
                           ((level_q == 2'd1) && (pte_ppn[8:0]  != 9'd0)));
  // A pointer at level 0 has nowhere left to go.
  assign pte_fault = pte_bad || pte_misaligned || (!pte_leaf && (level_q == 2'd0));

  // VPN slice indexing the table at the current level.
  logic [8:0] vpn_idx;
  always_comb begin
    case (level_q)
      2'd2:    vpn_idx = vpn_q[26:18];
      2'd1:    vpn_idx = vpn_q[17:9];
      default: vpn_idx = vpn_q[8:0];
    endcase
  end

  assign ptw_ready_o      = (state_q == S_IDLE);
  assign mem_req_valid_o  = (state_q == S_MEM_REQ);
  assign mem_req_addr_o   = (state_q == S_MEM_REQ) ? {base_q, vpn_idx, 3'b000} : 56'd0;
  assign resp_valid_o     = (state_q == S_RESP);
  assign resp_pte_o       = rpte_q;
  assign resp_level_o     = rlevel_q;
  assign resp_asid_o      = rasid_q;
  assign resp_error_o     = rerr_q;
  // Flush only invalidates the TLB; an in-flight walk is left to complete.
  assign invalidate_tlb_o = flush_i;

  // Walk sequencing and response capture.
  always_comb begin
    state_d  = state_q;
    vpn_d    = vpn_q;
    asid_d   = asid_q;
    base_d   = base_q;
    level_d  = level_q;
    rpte_d   = rpte_q;
    rlevel_d = rlevel_q;
    rasid_d  = rasid_q;
    rerr_d   = rerr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          vpn_d   = req_vpn_i;
          asid_d  = req_asid_i;
          base_d  = satp_ppn_i;
          level_d = 2'd2;
          state_d = S_MEM_REQ;
        end
      end
      S_MEM_REQ: begin
        if (mem_req_ready_i) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (mem_resp_valid_i) begin
          if (pte_fault || pte_leaf) begin
            rpte_d   = mem_resp_data_i;
            rlevel_d = level_q;
            rasid_d  = asid_q;
            rerr_d   = pte_fault;
            state_d  = S_RESP;
          end else begin
            base_d  = pte_ppn;
            level_d = level_q - 2'd1;
            state_d = S_MEM_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any walk and clears everything latched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      vpn_q    <= '0;
      asid_q   <= '0;
      base_q   <= '0;
      level_q  <= '0;
      rpte_q   <= '0;
      rlevel_q <= '0;
      rasid_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vpn_q    <= vpn_d;
      asid_q   <= asid_d;
      base_q   <= base_d;
      level_q  <= level_d;
      rpte_q   <= rpte_d;
      rlevel_q <= rlevel_d;
      rasid_q  <= rasid_d;
      rerr_q   <= rerr_d;
    end
  end

endmodule
